// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the multi-channel timer:
//   state_t          channel state encoding (IDLE=00, RUN=01, ROLL=11)
//   PS_W_DEFAULT     default prescaler-select width
//   ps_cnt_w()       prescaler counter width for a given select width
// ---------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        ROLL = 2'b11
    } state_t;

    localparam int unsigned PS_W_DEFAULT = 3;

    // A select of ps needs ps low bits of the prescaler counter; the largest
    // select is 2^ps_w - 1, so that is the counter width.
    function automatic int unsigned ps_cnt_w(input int unsigned ps_w);
        return (32'd1 << ps_w) - 32'd1;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// ---------------------------------------------------------------------------
// timer_channel
// One up-counting timer channel with clock-enable prescaler, one-shot /
// auto-reload operation and registered PWM output.
// Optional capture unit when TIMER_CAPTURE_EN is defined.
//
// Ports:
//   clk_in, rst        clock, synchronous active-high reset
//   en                 low forces IDLE
//   go                 start request, level sampled in IDLE
//   stop               abort; RUN/ROLL return to IDLE
//   auto_load          reload on rollover and continue
//   pwm_mode           enables pwm_out
//   prescaler_conf     divide select (ratio 2^ps)
//   load_val, cmp_val  start/reload value, PWM compare value
//   count              live counter value
//   busy               state != IDLE
//   tmr_int, go_clear  one-cycle rollover pulses
//   pwm_out            registered PWM output
//   cap_in/cap_val/cap_int  (TIMER_CAPTURE_EN only) async capture input,
//                      captured count, one-cycle capture pulse
// ---------------------------------------------------------------------------
module timer_channel
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned PS_W  = PS_W_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             go,
    input  logic             stop,
    input  logic             auto_load,
    input  logic             pwm_mode,
    input  logic [PS_W-1:0]  prescaler_conf,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tmr_int,
    output logic             go_clear,
`ifdef TIMER_CAPTURE_EN
    input  logic             cap_in,
    output logic [WIDTH-1:0] cap_val,
    output logic             cap_int,
`endif
    output logic             pwm_out
);

    localparam int unsigned PSC_W = ps_cnt_w(PS_W);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   count_nxt;
    logic [PSC_W-1:0]   ps_cnt, ps_nxt, ps_mask;
    logic               tick;
    logic               roll_pulse, roll_nxt;

    always_comb begin
        ps_mask   = (PSC_W'(1) << prescaler_conf) - PSC_W'(1);
        tick      = (prescaler_conf == '0) || ((ps_cnt & ps_mask) == ps_mask);
        state_nxt = state;
        count_nxt = count;
        ps_nxt    = ps_cnt + PSC_W'(1);
        roll_nxt  = 1'b0;
        // !en and stop outrank the state logic, including a rollover on the
        // same cycle, so the pulse is never raised for an aborted channel.
        if (!en || stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state_nxt = RUN;
                        count_nxt = load_val;
                        ps_nxt    = '0;
                    end
                end
                RUN: begin
                    if (tick) begin
                        count_nxt = count + WIDTH'(1);
                        if (&count) begin
                            state_nxt = ROLL;
                            roll_nxt  = 1'b1;
                        end
                    end
                end
                ROLL: begin
                    if (auto_load) begin
                        state_nxt = RUN;
                        count_nxt = load_val;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            ps_cnt     <= '0;
            roll_pulse <= 1'b0;
            pwm_out    <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            ps_cnt     <= ps_nxt;
            roll_pulse <= roll_nxt;
            pwm_out    <= pwm_mode && (state == RUN) && (count < cmp_val);
        end
    end

    assign busy     = (state != IDLE);
    assign tmr_int  = roll_pulse;
    assign go_clear = roll_pulse;

`ifdef TIMER_CAPTURE_EN
    logic [2:0] cap_sync;
    logic       cap_edge;

    assign cap_edge = cap_sync[1] && !cap_sync[2];

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cap_sync <= '0;
            cap_val  <= '0;
            cap_int  <= 1'b0;
        end else begin
            cap_sync <= {cap_sync[1:0], cap_in};
            cap_int  <= 1'b0;
            if (cap_edge && (state == RUN)) begin
                cap_val <= count;
                cap_int <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/timer_multi.sv
// ---------------------------------------------------------------------------
// timer_multi
// NCH independent WIDTH-bit timer channels; this level only slices the
// packed per-channel vectors onto timer_channel instances.
// Optional capture ports/logic when TIMER_CAPTURE_EN is defined.
//
// Ports (channel i occupies bit i, [i*PS_W +: PS_W] or [i*WIDTH +: WIDTH]):
//   clk_in, rst                          clock, synchronous active-high reset
//   en, go, stop, auto_load, pwm_mode    per-channel controls
//   prescaler_conf                       per-channel divide select
//   load_val, cmp_val                    per-channel load / compare values
//   count, busy, tmr_int, go_clear, pwm_out   per-channel status
//   cap_in, cap_val, cap_int             capture (TIMER_CAPTURE_EN only)
// ---------------------------------------------------------------------------
module timer_multi
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NCH   = 2,
    parameter int unsigned PS_W  = PS_W_DEFAULT
) (
    input  logic [0:0]           clk_in,
    input  logic                 rst,
    input  logic [NCH-1:0]       en,
    input  logic [NCH-1:0]       go,
    input  logic [NCH-1:0]       stop,
    input  logic [NCH-1:0]       auto_load,
    input  logic [NCH-1:0]       pwm_mode,
    input  logic [NCH*PS_W-1:0]  prescaler_conf,
    input  logic [NCH*WIDTH-1:0] load_val,
    input  logic [NCH*WIDTH-1:0] cmp_val,
    output logic [NCH*WIDTH-1:0] count,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       tmr_int,
    output logic [NCH-1:0]       go_clear,
`ifdef TIMER_CAPTURE_EN
    input  logic [NCH-1:0]       cap_in,
    output logic [NCH*WIDTH-1:0] cap_val,
    output logic [NCH-1:0]       cap_int,
`endif
    output logic [NCH-1:0]       pwm_out
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        timer_channel #(
            .WIDTH (WIDTH),
            .PS_W  (PS_W)
        ) u_ch (
            .clk_in         (clk_in[0]),
            .rst            (rst),
            .en             (en[i]),
            .go             (go[i]),
            .stop           (stop[i]),
            .auto_load      (auto_load[i]),
            .pwm_mode       (pwm_mode[i]),
            .prescaler_conf (prescaler_conf[i*PS_W +: PS_W]),
            .load_val       (load_val[i*WIDTH +: WIDTH]),
            .cmp_val        (cmp_val[i*WIDTH +: WIDTH]),
            .count          (count[i*WIDTH +: WIDTH]),
            .busy           (busy[i]),
            .tmr_int        (tmr_int[i]),
            .go_clear       (go_clear[i]),
`ifdef TIMER_CAPTURE_EN
            .cap_in         (cap_in[i]),
            .cap_val        (cap_val[i*WIDTH +: WIDTH]),
            .cap_int        (cap_int[i]),
`endif
            .pwm_out        (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_timer_multi.sv
// ---------------------------------------------------------------------------
// tb_timer_multi
// Self-checking bench for timer_multi (WIDTH=16, NCH=2, PS_W=3).
// A per-channel behavioural model tracks each channel in terms of edges
// elapsed since start, and a compare process checks every output each cycle.
// Directed sequences add literal expectations. Capture checks are included
// when TIMER_CAPTURE_EN is defined.
// ---------------------------------------------------------------------------
module tb_timer_multi;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NCH   = 2;
    localparam int unsigned PS_W  = 3;
    localparam int unsigned MAXV  = 32'h0000_FFFF;

    logic [0:0]           clk_in = 1'b0;
    logic                 rst;
    logic [NCH-1:0]       en, go, stop, auto_load, pwm_mode;
    logic [NCH*PS_W-1:0]  prescaler_conf;
    logic [NCH*WIDTH-1:0] load_val, cmp_val;
    logic [NCH*WIDTH-1:0] count;
    logic [NCH-1:0]       busy, tmr_int, go_clear, pwm_out;
`ifdef TIMER_CAPTURE_EN
    logic [NCH-1:0]       cap_in;
    logic [NCH*WIDTH-1:0] cap_val;
    logic [NCH-1:0]       cap_int;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    timer_multi #(
        .WIDTH (WIDTH),
        .NCH   (NCH),
        .PS_W  (PS_W)
    ) dut (
        .clk_in         (clk_in),
        .rst            (rst),
        .en             (en),
        .go             (go),
        .stop           (stop),
        .auto_load      (auto_load),
        .pwm_mode       (pwm_mode),
        .prescaler_conf (prescaler_conf),
        .load_val       (load_val),
        .cmp_val        (cmp_val),
        .count          (count),
        .busy           (busy),
        .tmr_int        (tmr_int),
        .go_clear       (go_clear),
`ifdef TIMER_CAPTURE_EN
        .cap_in         (cap_in),
        .cap_val        (cap_val),
        .cap_int        (cap_int),
`endif
        .pwm_out        (pwm_out)
    );

    task automatic chk(input string nm, input int ch, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ch%0d t=%0t actual=%h required=%h", nm, ch, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input int ch);
        return 32'(count[ch*WIDTH +: WIDTH]);
    endfunction

    // ---------------- behavioural model ----------------
    // Channel phase: 0 idle, 1 counting, 2 rollover cycle.
    // A prescaled channel advances on every 2^ps-th edge after its start.
    int          m_ph  [NCH];
    int unsigned m_val [NCH];
    int unsigned m_age [NCH];
    bit          m_tmr [NCH];
    bit          m_pwm [NCH];
    bit          started = 1'b0;

    initial begin
        forever begin
            @(posedge clk_in);
            for (int i = 0; i < NCH; i++) begin
                int unsigned div;
                int unsigned ld;
                if (rst) begin
                    m_ph[i] = 0; m_val[i] = 0; m_age[i] = 0; m_tmr[i] = 0; m_pwm[i] = 0;
                end else begin
                    div = 32'd1 << prescaler_conf[i*PS_W +: PS_W];
                    ld  = 32'(load_val[i*WIDTH +: WIDTH]);
                    m_pwm[i] = pwm_mode[i] && (m_ph[i] == 1) && (m_val[i] < 32'(cmp_val[i*WIDTH +: WIDTH]));
                    m_tmr[i] = 1'b0;
                    m_age[i] = (m_age[i] + 1) % 128;
                    if (!en[i] || stop[i]) begin
                        m_ph[i] = 0;
                    end else if (m_ph[i] == 0) begin
                        if (go[i]) begin
                            m_ph[i] = 1; m_val[i] = ld; m_age[i] = 0;
                        end
                    end else if (m_ph[i] == 1) begin
                        if (m_age[i] % div == 0) begin
                            if (m_val[i] == MAXV) begin
                                m_val[i] = 0; m_tmr[i] = 1'b1; m_ph[i] = 2;
                            end else begin
                                m_val[i] = m_val[i] + 1;
                            end
                        end
                    end else begin
                        if (auto_load[i]) begin
                            m_ph[i] = 1; m_val[i] = ld;
                        end else begin
                            m_ph[i] = 0;
                        end
                    end
                end
            end
            started = 1'b1;
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk_in);
            if (started) begin
                for (int i = 0; i < NCH; i++) begin
                    chk("model_count",    i, cnt(i), m_val[i]);
                    chk("model_busy",     i, 32'(busy[i]), 32'(m_ph[i] != 0));
                    chk("model_tmr_int",  i, 32'(tmr_int[i]), 32'(m_tmr[i]));
                    chk("model_go_clear", i, 32'(go_clear[i]), 32'(m_tmr[i]));
                    chk("model_pwm_out",  i, 32'(pwm_out[i]), 32'(m_pwm[i]));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n = 1);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic setch(input int ch, input int unsigned ps, input int unsigned ld,
                         input int unsigned cv, input bit al, input bit pm);
        prescaler_conf[ch*PS_W +: PS_W] = PS_W'(ps);
        load_val[ch*WIDTH +: WIDTH]     = WIDTH'(ld);
        cmp_val[ch*WIDTH +: WIDTH]      = WIDTH'(cv);
        auto_load[ch]                   = al;
        pwm_mode[ch]                    = pm;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
        $fatal(1);
    end

    initial begin
        int n, t0, t1, hi, ni;
        logic [31:0] cv;

        rst = 1'b1; en = '0; go = '0; stop = '0; auto_load = '0; pwm_mode = '0;
        prescaler_conf = '0; load_val = '0; cmp_val = '0;
`ifdef TIMER_CAPTURE_EN
        cap_in = '0;
`endif
        step(3);
        chk("reset_count", 0, cnt(0), 32'h0);
        chk("reset_busy",  0, 32'(busy), 32'h0);
        chk("reset_tmr",   0, 32'(tmr_int), 32'h0);
        chk("reset_pwm",   0, 32'(pwm_out), 32'h0);
        rst = 1'b0;
        step;

        // one-shot, ps=0, load FFFE
        setch(0, 0, 32'hFFFE, 0, 1'b0, 1'b0);
        en = 2'b11; go[0] = 1'b1;
        step;  chk("os_e0_count", 0, cnt(0), 32'hFFFE); chk("os_e0_busy", 0, 32'(busy[0]), 1);
        go[0] = 1'b0;
        step;  chk("os_e1_count", 0, cnt(0), 32'hFFFF);
        step;  chk("os_e2_count", 0, cnt(0), 32'h0);
               chk("os_e2_tmr", 0, 32'(tmr_int[0]), 1); chk("os_e2_goclr", 0, 32'(go_clear[0]), 1);
        step;  chk("os_e3_busy", 0, 32'(busy[0]), 0); chk("os_e3_tmr", 0, 32'(tmr_int[0]), 0);
        step(3); chk("os_hold_count", 0, cnt(0), 32'h0);

        // go held high after one-shot restarts the channel
        go[0] = 1'b1;
        step(4); chk("restart_idle", 0, 32'(busy[0]), 0);
        step;    chk("restart_busy", 0, 32'(busy[0]), 1); chk("restart_count", 0, cnt(0), 32'hFFFE);
        go[0] = 1'b0;
        step(3); chk("restart_done", 0, 32'(busy[0]), 0);

        // auto-reload, go pulsed
        setch(0, 0, 32'hFFFE, 0, 1'b1, 1'b0);
        go[0] = 1'b1;
        step; go[0] = 1'b0;
        step(2); chk("al_e2_tmr", 0, 32'(tmr_int[0]), 1);
        step;    chk("al_e3_count", 0, cnt(0), 32'hFFFE);
        step(2); chk("al_e5_tmr", 0, 32'(tmr_int[0]), 1);
        step(4); chk("al_e9_count", 0, cnt(0), 32'hFFFE);
        en[0] = 1'b0;
        step;    chk("en_low_busy", 0, 32'(busy[0]), 0); chk("en_low_count", 0, cnt(0), 32'hFFFE);
        step(2); chk("en_low_frozen", 0, cnt(0), 32'hFFFE);
        en[0] = 1'b1;
        step;

        // ps=3, load FFFC: rollover 32 edges after the start edge
        setch(0, 3, 32'hFFFC, 0, 1'b0, 1'b0);
        go[0] = 1'b1;
        step; go[0] = 1'b0;
        step(8); chk("ps3_e8_count", 0, cnt(0), 32'hFFFD);
        n = 8;
        while (!tmr_int[0] && n < 100) begin step; n++; end
        chk("ps3_latency", 0, 32'(n), 32);
        step(2);

        // load all ones: rollover on the first tick
        setch(0, 0, 32'hFFFF, 0, 1'b0, 1'b0);
        go[0] = 1'b1;
        step; chk("ones_e0_count", 0, cnt(0), 32'hFFFF);
        go[0] = 1'b0;
        step; chk("ones_e1_tmr", 0, 32'(tmr_int[0]), 1); chk("ones_e1_count", 0, cnt(0), 32'h0);
        step(2);

        // stop on the rollover cycle
        setch(0, 0, 32'hFFFE, 0, 1'b0, 1'b0);
        go[0] = 1'b1;
        step; go[0] = 1'b0;
        step; stop[0] = 1'b1;
        step; chk("stop_tmr", 0, 32'(tmr_int[0]), 0); chk("stop_goclr", 0, 32'(go_clear[0]), 0);
              chk("stop_busy", 0, 32'(busy[0]), 0); chk("stop_count", 0, cnt(0), 32'hFFFF);
        stop[0] = 1'b0;
        step; chk("stop_after_tmr", 0, 32'(tmr_int[0]), 0);

        // en dropped mid-run
        setch(0, 0, 32'h1000, 0, 1'b0, 1'b0);
        go[0] = 1'b1;
        step; go[0] = 1'b0;
        step(4); chk("mid_count", 0, cnt(0), 32'h1004);
        en[0] = 1'b0;
        step;    chk("mid_busy", 0, 32'(busy[0]), 0); chk("mid_count_frozen", 0, cnt(0), 32'h1004);
        step(3); chk("mid_count_still", 0, cnt(0), 32'h1004);
        en[0] = 1'b1;
        step;

        // two channels, independent prescalers
        setch(0, 0, 32'hFFF0, 0, 1'b0, 1'b0);
        setch(1, 2, 32'hFFF0, 0, 1'b0, 1'b0);
        go = 2'b11;
        step; go = 2'b00;
        n = 0; t0 = -1; t1 = -1;
        while (n < 200 && (t0 < 0 || t1 < 0)) begin
            step; n++;
            if (tmr_int[0] && t0 < 0) t0 = n;
            if (tmr_int[1] && t1 < 0) t1 = n;
        end
        chk("dual_ch0_latency", 0, 32'(t0), 16);
        chk("dual_ch1_latency", 1, 32'(t1), 64);
        step(3);

        // PWM: 256 counting cycles + 1 rollover cycle per period
        setch(0, 0, 32'hFF00, 32'hFF40, 1'b1, 1'b1);
        go[0] = 1'b1;
        step; go[0] = 1'b0;
        step(300);
        hi = 0;
        for (int k = 0; k < 257; k++) begin step; hi += int'(pwm_out[0]); end
        chk("pwm_high_per_period", 0, 32'(hi), 64);
        cmp_val[0 +: WIDTH] = '0;
        step(2);
        hi = 0;
        for (int k = 0; k < 257; k++) begin step; hi += int'(pwm_out[0]); end
        chk("pwm_cmp0_high", 0, 32'(hi), 0);
        en[0] = 1'b0;
        step(2);
        pwm_mode[0] = 1'b0; auto_load[0] = 1'b0; en[0] = 1'b1;
        step;

`ifdef TIMER_CAPTURE_EN
        setch(0, 0, 32'h0000, 0, 1'b0, 1'b0);
        go[0] = 1'b1;
        step; go[0] = 1'b0;
        n = 0;
        while (cnt(0) != 32'h10 && n < 50) begin step; n++; end
        chk("cap_reach_0x10", 0, cnt(0), 32'h10);
        cap_in[0] = 1'b1;
        ni = 0; cv = '0;
        for (int k = 0; k < 8; k++) begin
            step;
            if (cap_int[0]) begin ni++; cv = 32'(cap_val[0 +: WIDTH]); end
        end
        chk("cap_int_pulses", 0, 32'(ni), 1);
        chk("cap_val_in_range", 0, 32'(cv >= 32'h10 && cv <= 32'h12), 1);
        cap_in[0] = 1'b0;
        en[0] = 1'b0;
        step(2);
        en[0] = 1'b1;
        step;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
